// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } ifu_state_t;

    // One fetch-queue slot: the word and the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } ifu_entry_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, instruction} entries with push, pop and
// flush. Flush wins over push/pop. DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  ifu_entry_t               push_entry,
    output ifu_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    ifu_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop needs an entry; a push needs room unless a pop frees a slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    assign head = mem[rd_ptr];

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the instruction-memory address, captures
// the combinationally returned word into a small queue and presents it to
// decode over valid/ready. Redirects flush the queue and reload the PC.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned redirect traps
// and halts fetch; without it redirect targets are forced word-aligned).
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic        fetch_exception
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    ifu_state_t    state;
    ifu_state_t    state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   redirect_target;
    logic [CW-1:0] count;
    logic          q_full;
    logic          q_empty;
    logic          push;
    logic          pop;
    logic          flush;
    ifu_entry_t    head;
    ifu_entry_t    push_entry;
`ifdef IFU_MISALIGN_TRAP_EN
    logic          trap;
`endif

`ifdef IFU_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
`else
    assign redirect_target = redirect_pc & ~32'h3;
`endif

    assign q_full  = (count == CW'(QUEUE_DEPTH));
    assign q_empty = (count == '0);

    assign imem_pc         = pc;
    assign out_valid       = !q_empty && (state != HALT);
    assign out_instruction = head.instruction;
    assign out_pc          = head.pc;

    // A handshake coinciding with a redirect is harmless: flush wins inside
    // the queue, so the popped entry is simply discarded with the rest.
    assign pop        = out_valid && out_ready;
    assign push_entry = '{pc: pc, instruction: imem_instruction};

    // Next state, next PC and queue controls; redirect takes priority.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        trap       = 1'b0;
`endif
        case (state)
            BOOT: begin
                state_next = FETCH;
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = redirect_target;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        trap       = 1'b1;
                        state_next = HALT;
                    end else begin
                        pc_next = redirect_target;
                    end
`else
                    pc_next = redirect_target;
`endif
                end else if (!q_full || pop) begin
                    push    = 1'b1;
                    pc_next = pc + PC_STEP;
                end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            HALT: begin
                // Frozen until reset.
            end
`endif
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_exception <= 1'b0;
        end else if (trap) begin
            fetch_exception <= 1'b1;
        end
    end
`endif

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

endmodule
